// File: rtl/phv_xbar_pkg.sv
// Shared definitions for the PHV operand crossbar: opcode values, operand
// source classes and the action-word field placement helper.
package phv_xbar_pkg;

  localparam int OPC_W = 8;

  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_SUB  = 8'h02;
  localparam logic [7:0] OP_ADDI = 8'h03;
  localparam logic [7:0] OP_AND  = 8'h04;
  localparam logic [7:0] OP_ANDI = 8'h05;
  localparam logic [7:0] OP_OR   = 8'h06;
  localparam logic [7:0] OP_ORI  = 8'h07;
  localparam logic [7:0] OP_XOR  = 8'h08;
  localparam logic [7:0] OP_XORI = 8'h09;
  localparam logic [7:0] OP_SUBI = 8'h0A;
  localparam logic [7:0] OP_MIN  = 8'h0B;
  localparam logic [7:0] OP_ADD3 = 8'h0C;
  localparam logic [7:0] OP_SET  = 8'h0E;
  localparam logic [7:0] OP_SEL  = 8'h10;
  localparam logic [7:0] OP_SELI = 8'h11;
  localparam logic [7:0] OP_MAX  = 8'h12;
  localparam logic [7:0] OP_SHL  = 8'h13;
  localparam logic [7:0] OP_CPY  = 8'h14;
  localparam logic [7:0] OP_SHR  = 8'h17;
  localparam logic [7:0] OP_EQ   = 8'h18;
  localparam logic [7:0] OP_SHLI = 8'h1B;
  localparam logic [7:0] OP_NE   = 8'h1C;
  localparam logic [7:0] OP_SHRI = 8'h1D;

  // Field numbers for fld_lsb: opcode first, then the three index fields.
  localparam int FLD_OPC  = 0;
  localparam int FLD_IDXA = 1;
  localparam int FLD_IDXB = 2;
  localparam int FLD_IDXC = 3;

  typedef enum logic [2:0] {
    CLS_DEF,
    CLS_PP,
    CLS_PI,
    CLS_SET,
    CLS_Z,
    CLS_PPP,
    CLS_PPI
  } op_cls_e;

  // LSB position of a field packed downward from the top of the action word.
  function automatic int fld_lsb(input int act_w, input int idx_w, input int fld);
    return act_w - OPC_W - fld * idx_w;
  endfunction

  function automatic op_cls_e op_class(input logic [7:0] op);
    op_cls_e cls;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MIN,
      OP_MAX, OP_SHL, OP_SHR, OP_EQ, OP_NE:           cls = CLS_PP;
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SUBI,
      OP_SHLI, OP_SHRI:                               cls = CLS_PI;
      OP_SET:                                         cls = CLS_SET;
      OP_CPY:                                         cls = CLS_Z;
      OP_ADD3, OP_SEL:                                cls = CLS_PPP;
      OP_SELI:                                        cls = CLS_PPI;
      default:                                        cls = CLS_DEF;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/phv_operand_xbar_op_decode.sv
// Per-container operand selection: decodes one action slot and picks the
// four ALU operands from the (zero-padded) container array.
module xbar_op_decode
  import phv_xbar_pkg::*;
#(
  parameter int CONT_W = 32,
  parameter int IDX_W  = 6
) (
  input  logic [7:0]        i_opcode,
  input  logic [IDX_W-1:0]  i_idx_a,
  input  logic [IDX_W-1:0]  i_idx_b,
  input  logic [IDX_W-1:0]  i_idx_c,
  input  logic [CONT_W-1:0] i_imm,
  input  logic [CONT_W-1:0] i_self,
  input  logic [CONT_W-1:0] i_cont [1 << IDX_W],
  output logic [CONT_W-1:0] o_a,
  output logic [CONT_W-1:0] o_b,
  output logic [CONT_W-1:0] o_c,
  output logic [CONT_W-1:0] o_d
);

  localparam logic [CONT_W-1:0] ZERO = {CONT_W{1'b0}};

  op_cls_e           w_cls;
  logic [CONT_W-1:0] w_src_a;
  logic [CONT_W-1:0] w_src_b;
  logic [CONT_W-1:0] w_src_c;

  // Entries past NUM_CONT are tied to zero by the caller, so out-of-range
  // indices read zero without a compare here.
  assign w_cls   = op_class(i_opcode);
  assign w_src_a = i_cont[i_idx_a];
  assign w_src_b = i_cont[i_idx_b];
  assign w_src_c = i_cont[i_idx_c];
  assign o_d     = i_self;

  // Operand source mux by opcode class
  always_comb begin
    o_a = i_self;
    o_b = ZERO;
    o_c = i_self;
    case (w_cls)
      CLS_PP: begin
        o_a = w_src_a;
        o_b = w_src_b;
      end
      CLS_PI: begin
        o_a = w_src_a;
        o_b = i_imm;
      end
      CLS_SET: begin
        o_a = ZERO;
        o_b = i_imm;
      end
      CLS_Z: begin
        o_a = w_src_a;
        o_b = ZERO;
      end
      CLS_PPP: begin
        o_a = w_src_a;
        o_b = w_src_b;
        o_c = w_src_c;
      end
      CLS_PPI: begin
        o_a = w_src_a;
        o_b = w_src_b;
        o_c = i_imm;
      end
      default: begin
        o_a = i_self;
        o_b = ZERO;
      end
    endcase
  end

endmodule

// File: rtl/phv_operand_xbar.sv
// RMT action-stage operand crossbar with a lossless main+skid output stage.
// Optional PHV_XBAR_STATS_EN adds saturating stat_pkts / stat_stall counters.
module phv_operand_xbar
  import phv_xbar_pkg::*;
#(
  parameter int STAGE_ID = 0,
  parameter int NUM_CONT = 64,
  parameter int CONT_W   = 32,
  parameter int REMAIN_W = 256,
  parameter int ACT_W    = 64,
  parameter int PHV_LEN  = NUM_CONT * CONT_W + REMAIN_W,
  parameter int IDX_W    = $clog2(NUM_CONT)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PHV_LEN-1:0]            phv_in,
  input  logic                          phv_in_valid,
  input  logic [ACT_W*(NUM_CONT+1)-1:0] action_in,
  input  logic                          action_in_valid,
  output logic                          ready_out,
  output logic                          alu_in_valid,
  output logic [NUM_CONT*CONT_W-1:0]    alu_in_a,
  output logic [NUM_CONT*CONT_W-1:0]    alu_in_b,
  output logic [NUM_CONT*CONT_W-1:0]    alu_in_c,
  output logic [NUM_CONT*CONT_W-1:0]    alu_in_d,
  output logic [REMAIN_W-1:0]           phv_remain_data,
  output logic [ACT_W*(NUM_CONT+1)-1:0] action_out,
  output logic                          action_valid_out,
  input  logic                          ready_in
`ifdef PHV_XBAR_STATS_EN
  ,
  output logic [31:0]                   stat_pkts,
  output logic [31:0]                   stat_stall
`endif
);

  localparam int OPS_W    = NUM_CONT * CONT_W;
  localparam int ACTS_W   = ACT_W * (NUM_CONT + 1);
  localparam int A_OFF    = 0;
  localparam int B_OFF    = OPS_W;
  localparam int C_OFF    = 2 * OPS_W;
  localparam int D_OFF    = 3 * OPS_W;
  localparam int REM_OFF  = 4 * OPS_W;
  localparam int ACT_OFF  = 4 * OPS_W + REMAIN_W;
  localparam int BUN_W    = ACT_OFF + ACTS_W;
  localparam int EXT_N    = 1 << IDX_W;
  localparam int OPC_LSB  = fld_lsb(ACT_W, IDX_W, FLD_OPC);
  localparam int IDXA_LSB = fld_lsb(ACT_W, IDX_W, FLD_IDXA);
  localparam int IDXB_LSB = fld_lsb(ACT_W, IDX_W, FLD_IDXB);
  localparam int IDXC_LSB = fld_lsb(ACT_W, IDX_W, FLD_IDXC);

  if ((CONT_W > IDXC_LSB) || (EXT_N < NUM_CONT) ||
      (PHV_LEN != OPS_W + REMAIN_W) || (STAGE_ID < 0)) begin : g_bad_cfg
    $error("phv_operand_xbar: inconsistent parameters");
  end

  logic [CONT_W-1:0] w_cont_ext [EXT_N];
  logic [OPS_W-1:0]  w_a;
  logic [OPS_W-1:0]  w_b;
  logic [OPS_W-1:0]  w_c;
  logic [OPS_W-1:0]  w_d;
  logic [BUN_W-1:0]  w_bundle;
  logic              w_in_xfer;
  logic              w_main_free;

  logic              r_main_valid;
  logic              r_skid_valid;
  logic              r_ready;
  logic [BUN_W-1:0]  r_main;
  logic [BUN_W-1:0]  r_skid;

  // Index space padded to a power of two; the padding reads as zero.
  for (genvar k = 0; k < EXT_N; k++) begin : g_ext
    if (k < NUM_CONT) begin : g_cont
      assign w_cont_ext[k] = phv_in[PHV_LEN-1-CONT_W*(NUM_CONT-1-k) -: CONT_W];
    end else begin : g_zero
      assign w_cont_ext[k] = {CONT_W{1'b0}};
    end
  end

  // Container i is driven by action slot i+1; slot 0 only rides along.
  for (genvar i = 0; i < NUM_CONT; i++) begin : g_dec
    localparam int SLOT = (i + 1) * ACT_W;
    xbar_op_decode #(
      .CONT_W (CONT_W),
      .IDX_W  (IDX_W)
    ) u_dec (
      .i_opcode (action_in[SLOT+OPC_LSB +: OPC_W]),
      .i_idx_a  (action_in[SLOT+IDXA_LSB +: IDX_W]),
      .i_idx_b  (action_in[SLOT+IDXB_LSB +: IDX_W]),
      .i_idx_c  (action_in[SLOT+IDXC_LSB +: IDX_W]),
      .i_imm    (action_in[SLOT +: CONT_W]),
      .i_self   (w_cont_ext[i]),
      .i_cont   (w_cont_ext),
      .o_a      (w_a[i*CONT_W +: CONT_W]),
      .o_b      (w_b[i*CONT_W +: CONT_W]),
      .o_c      (w_c[i*CONT_W +: CONT_W]),
      .o_d      (w_d[i*CONT_W +: CONT_W])
    );
  end

  assign w_bundle    = {action_in, phv_in[REMAIN_W-1:0], w_d, w_c, w_b, w_a};
  assign w_in_xfer   = phv_in_valid & action_in_valid & r_ready;
  assign w_main_free = ~r_main_valid | ready_in;

  // Main/skid stage: skid only fills while main is stalled and drains first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_ready      <= 1'b1;
      r_main       <= {BUN_W{1'b0}};
      r_skid       <= {BUN_W{1'b0}};
    end else begin
      if (w_main_free) begin
        if (r_skid_valid) begin
          r_main       <= r_skid;
          r_main_valid <= 1'b1;
          r_skid_valid <= 1'b0;
          r_ready      <= 1'b1;
        end else begin
          r_main_valid <= w_in_xfer;
          if (w_in_xfer) begin
            r_main <= w_bundle;
          end
        end
      end else if (w_in_xfer) begin
        r_skid       <= w_bundle;
        r_skid_valid <= 1'b1;
        r_ready      <= 1'b0;
      end
    end
  end

  assign ready_out        = r_ready;
  assign alu_in_valid     = r_main_valid;
  assign action_valid_out = r_main_valid;
  assign alu_in_a         = r_main[A_OFF +: OPS_W];
  assign alu_in_b         = r_main[B_OFF +: OPS_W];
  assign alu_in_c         = r_main[C_OFF +: OPS_W];
  assign alu_in_d         = r_main[D_OFF +: OPS_W];
  assign phv_remain_data  = r_main[REM_OFF +: REMAIN_W];
  assign action_out       = r_main[ACT_OFF +: ACTS_W];

`ifdef PHV_XBAR_STATS_EN
  logic [31:0] r_stat_pkts;
  logic [31:0] r_stat_stall;

  // Saturating transfer and stall counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_pkts  <= 32'd0;
      r_stat_stall <= 32'd0;
    end else begin
      if (w_in_xfer && (r_stat_pkts != 32'hFFFF_FFFF)) begin
        r_stat_pkts <= r_stat_pkts + 32'd1;
      end
      if (r_main_valid && !ready_in && (r_stat_stall != 32'hFFFF_FFFF)) begin
        r_stat_stall <= r_stat_stall + 32'd1;
      end
    end
  end

  assign stat_pkts  = r_stat_pkts;
  assign stat_stall = r_stat_stall;
`endif

endmodule

// File: tb/tb_phv_operand_xbar.sv
// Scoreboard bench for phv_operand_xbar (16 containers, 5-bit index field so
// out-of-range indices can be exercised); reference model built from the opcode tables.
module tb_phv_operand_xbar;

  localparam int NC = 16;
  localparam int CW = 32;
  localparam int RW = 256;
  localparam int AW = 64;
  localparam int IW = 5;
  localparam int PL = NC * CW + RW;
  localparam int OW = NC * CW;
  localparam int AX = AW * (NC + 1);

  typedef struct packed {
    logic [AX-1:0] act;
    logic [RW-1:0] rem;
    logic [OW-1:0] d;
    logic [OW-1:0] c;
    logic [OW-1:0] b;
    logic [OW-1:0] a;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [PL-1:0] phv_in;
  logic          phv_in_valid;
  logic [AX-1:0] action_in;
  logic          action_in_valid;
  logic          ready_out;
  logic          alu_in_valid;
  logic [OW-1:0] alu_in_a, alu_in_b, alu_in_c, alu_in_d;
  logic [RW-1:0] phv_remain_data;
  logic [AX-1:0] action_out;
  logic          action_valid_out;
  logic          ready_in;
`ifdef PHV_XBAR_STATS_EN
  logic [31:0]   stat_pkts, stat_stall;
`endif

  int   n_checks = 0;
  int   n_fails  = 0;
  int   n_sent   = 0;
  int   n_stall  = 0;
  logic rdy_level = 1'b1;
  logic rdy_rand  = 1'b0;
  exp_t q[$];
  exp_t mon_e;

  phv_operand_xbar #(
    .STAGE_ID (0), .NUM_CONT (NC), .CONT_W (CW), .REMAIN_W (RW),
    .ACT_W (AW), .IDX_W (IW)
  ) u_dut (
    .clk (clk), .rst_n (rst_n), .phv_in (phv_in), .phv_in_valid (phv_in_valid),
    .action_in (action_in), .action_in_valid (action_in_valid), .ready_out (ready_out),
    .alu_in_valid (alu_in_valid), .alu_in_a (alu_in_a), .alu_in_b (alu_in_b),
    .alu_in_c (alu_in_c), .alu_in_d (alu_in_d), .phv_remain_data (phv_remain_data),
    .action_out (action_out), .action_valid_out (action_valid_out), .ready_in (ready_in)
`ifdef PHV_XBAR_STATS_EN
    , .stat_pkts (stat_pkts), .stat_stall (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, expv);
    end
  endtask

  function automatic logic [CW-1:0] cont_of(input logic [PL-1:0] phv, input int k);
    if (k >= NC) return {CW{1'b0}};
    return phv[PL-1-CW*(NC-1-k) -: CW];
  endfunction

  function automatic exp_t model(input logic [PL-1:0] phv, input logic [AX-1:0] act);
    exp_t e;
    e.rem = phv[RW-1:0];
    e.act = act;
    for (int i = 0; i < NC; i++) begin
      logic [AW-1:0] w;
      logic [7:0]    op;
      logic [CW-1:0] imm, a, b, c;
      int            ia, ib, ic;
      w   = act[(i+1)*AW +: AW];
      op  = w[AW-1 -: 8];
      ia  = int'(w[AW-9 -: IW]);
      ib  = int'(w[AW-9-IW -: IW]);
      ic  = int'(w[AW-9-2*IW -: IW]);
      imm = w[CW-1:0];
      a = cont_of(phv, i);
      b = {CW{1'b0}};
      c = cont_of(phv, i);
      if (op inside {8'h01, 8'h02, 8'h04, 8'h06, 8'h08, 8'h0B, 8'h12, 8'h13, 8'h17, 8'h18, 8'h1C}) begin
        a = cont_of(phv, ia); b = cont_of(phv, ib);
      end else if (op inside {8'h03, 8'h05, 8'h07, 8'h09, 8'h0A, 8'h1B, 8'h1D}) begin
        a = cont_of(phv, ia); b = imm;
      end else if (op == 8'h0E) begin
        a = {CW{1'b0}}; b = imm;
      end else if (op == 8'h14) begin
        a = cont_of(phv, ia);
      end else if (op inside {8'h0C, 8'h10}) begin
        a = cont_of(phv, ia); b = cont_of(phv, ib); c = cont_of(phv, ic);
      end else if (op == 8'h11) begin
        a = cont_of(phv, ia); b = cont_of(phv, ib); c = imm;
      end
      e.a[(i+1)*CW-1 -: CW] = a;
      e.b[(i+1)*CW-1 -: CW] = b;
      e.c[(i+1)*CW-1 -: CW] = c;
      e.d[(i+1)*CW-1 -: CW] = cont_of(phv, i);
    end
    return e;
  endfunction

  function automatic logic [AW-1:0] mk_act(input logic [7:0] op, input int ia, input int ib,
                                           input int ic, input logic [CW-1:0] imm);
    logic [AW-1:0] w;
    w = {AW{1'b0}};
    w[AW-1 -: 8]         = op;
    w[AW-9 -: IW]        = IW'(ia);
    w[AW-9-IW -: IW]     = IW'(ib);
    w[AW-9-2*IW -: IW]   = IW'(ic);
    w[CW-1:0]            = imm;
    return w;
  endfunction

  function automatic logic [PL-1:0] rand_phv();
    logic [PL-1:0] v;
    for (int j = 0; j < PL / 32; j++) v[j*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [PL-1:0] seq_phv();
    logic [PL-1:0] v;
    v = rand_phv();
    for (int k = 0; k < NC; k++) v[PL-1-CW*(NC-1-k) -: CW] = CW'(k + 100);
    return v;
  endfunction

  function automatic logic [AX-1:0] rand_act();
    logic [7:0]    ops [14];
    logic [AX-1:0] v;
    ops = '{8'h01, 8'h02, 8'h03, 8'h0E, 8'h14, 8'h0C, 8'h10, 8'h11, 8'hFF, 8'h00, 8'h1D, 8'h17, 8'h0B, 8'h1B};
    v[AW-1:0] = {$urandom(), $urandom()};
    for (int s = 1; s <= NC; s++)
      v[s*AW +: AW] = mk_act(ops[$urandom_range(0, 13)], int'($urandom_range(0, 31)),
                             int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), $urandom());
    return v;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic [PL-1:0] phv, input logic [AX-1:0] act);
    int n = 0;
    phv_in = phv; action_in = act; phv_in_valid = 1'b1; action_in_valid = 1'b1;
    while (!ready_out && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("send_accept", 512'(ready_out), 512'(1'b1));
    if (ready_out) begin
      q.push_back(model(phv, act));
      n_sent++;
    end
    @(negedge clk);
    phv_in_valid = 1'b0; action_in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 512'(q.size()), 512'(0));
  endtask

  // Downstream ready, changed away from both clock edges
  initial begin
    ready_in = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      ready_in = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_level;
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && alu_in_valid) begin
      chk("valid_align", 512'(action_valid_out), 512'(1'b1));
      if (!ready_in) n_stall++;
      if (ready_in) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 512'(1'b1), 512'(1'b0));
        end else begin
          mon_e = q.pop_front();
          chk("a", alu_in_a, mon_e.a);
          chk("b", alu_in_b, mon_e.b);
          chk("c", alu_in_c, mon_e.c);
          chk("d", alu_in_d, mon_e.d);
          chk("remain", 512'(phv_remain_data), 512'(mon_e.rem));
          chk("act_lo", action_out[511:0], mon_e.act[511:0]);
          chk("act_mid", action_out[1023:512], mon_e.act[1023:512]);
          chk("act_hi", 512'(action_out[AX-1:1024]), 512'(mon_e.act[AX-1:1024]));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PL-1:0] p;
    logic [AX-1:0] a;
    logic [PL-1:0] bb_p [4];
    logic [AX-1:0] bb_a [4];

    rst_n = 1'b0; phv_in = {PL{1'b0}}; action_in = {AX{1'b0}};
    phv_in_valid = 1'b0; action_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 512'(alu_in_valid), 512'(1'b0));
    chk("rst_act_valid", 512'(action_valid_out), 512'(1'b0));
    chk("rst_ready", 512'(ready_out), 512'(1'b1));
    chk("rst_a", alu_in_a, 512'(0));
    chk("rst_act", action_out[511:0], 512'(0));
`ifdef PHV_XBAR_STATS_EN
    chk("rst_stat_pkts", 512'(stat_pkts), 512'(0));
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Directed: PP, SET and PPI on slots 1..3
    p = seq_phv();
    a = {AX{1'b0}};
    a[1*AW +: AW] = mk_act(8'h01, 3, 5, 0, 32'h0);
    a[2*AW +: AW] = mk_act(8'h0E, 0, 0, 0, 32'hDEADBEEF);
    a[3*AW +: AW] = mk_act(8'h11, 1, 2, 9, 32'h7);
    send(p, a);
    chk("latency_1", 512'(alu_in_valid), 512'(1'b1));
    chk("c0_a", 512'(alu_in_a[CW-1 -: CW]), 512'(103));
    chk("c0_b", 512'(alu_in_b[CW-1 -: CW]), 512'(105));
    chk("c0_c", 512'(alu_in_c[CW-1 -: CW]), 512'(100));
    chk("c0_d", 512'(alu_in_d[CW-1 -: CW]), 512'(100));
    chk("c1_a", 512'(alu_in_a[2*CW-1 -: CW]), 512'(0));
    chk("c1_b", 512'(alu_in_b[2*CW-1 -: CW]), 512'(32'hDEADBEEF));
    chk("c2_c", 512'(alu_in_c[3*CW-1 -: CW]), 512'(7));
    repeat (2) @(negedge clk);

    // Default opcode everywhere
    p = rand_phv();
    for (int s = 0; s <= NC; s++) a[s*AW +: AW] = mk_act(8'hFF, 7, 8, 9, $urandom());
    send(p, a);
    chk("ff_remain", 512'(phv_remain_data), 512'(p[RW-1:0]));
    chk("ff_b_zero", alu_in_b, 512'(0));

    // Index boundary: 15 valid, 16 and 31 select zero
    p = seq_phv();
    a = rand_act();
    a[1*AW +: AW] = mk_act(8'h01, 15, 16, 0, 32'h0);
    a[2*AW +: AW] = mk_act(8'h14, 31, 0, 0, 32'h0);
    a[3*AW +: AW] = mk_act(8'h0C, 0, 15, 20, 32'h0);
    send(p, a);
    chk("idx15", 512'(alu_in_a[CW-1 -: CW]), 512'(115));
    chk("idx16", 512'(alu_in_b[CW-1 -: CW]), 512'(0));
    chk("idx31", 512'(alu_in_a[2*CW-1 -: CW]), 512'(0));
    chk("idx20_c", 512'(alu_in_c[3*CW-1 -: CW]), 512'(0));
    wait_drain();

    // Back-to-back burst into a stalled output stage
    for (int j = 0; j < 4; j++) begin
      bb_p[j] = rand_phv();
      bb_a[j] = rand_act();
    end
    rdy_level = 1'b0;
    @(posedge clk);
    #3;
    @(negedge clk);
    fork
      begin
        for (int j = 0; j < 4; j++) send(bb_p[j], bb_a[j]);
      end
      begin
        repeat (2) @(posedge clk);
        #3;
        chk("skid_full_ready", 512'(ready_out), 512'(1'b0));
        chk("stall_hold_valid", 512'(alu_in_valid), 512'(1'b1));
        repeat (2) @(posedge clk);
        rdy_level = 1'b1;
      end
    join
    wait_drain();
    chk("ready_after_drain", 512'(ready_out), 512'(1'b1));

    // Random traffic under random backpressure
    rdy_rand = 1'b1;
    for (int t = 0; t < 300; t++) begin
      send(rand_phv(), rand_act());
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rdy_rand = 1'b0;
    rdy_level = 1'b1;
    repeat (2) @(negedge clk);
    wait_drain();
`ifdef PHV_XBAR_STATS_EN
    chk("stat_pkts", 512'(stat_pkts), 512'(n_sent));
    chk("stat_stall", 512'(stat_stall), 512'(n_stall));
`endif

    // Asynchronous reset with main and skid both occupied
    rdy_level = 1'b0;
    @(posedge clk);
    #3;
    @(negedge clk);
    send(rand_phv(), rand_act());
    send(rand_phv(), rand_act());
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 512'(alu_in_valid), 512'(1'b0));
    chk("mid_rst_ready", 512'(ready_out), 512'(1'b1));
    chk("mid_rst_a", alu_in_a, 512'(0));
`ifdef PHV_XBAR_STATS_EN
    chk("mid_rst_pkts", 512'(stat_pkts), 512'(0));
    chk("mid_rst_stall", 512'(stat_stall), 512'(0));
`endif
    q.delete();
    n_sent = 0;
    n_stall = 0;
    @(negedge clk);
    rst_n = 1'b1;
    rdy_level = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", 512'(alu_in_valid), 512'(1'b0));
    send(rand_phv(), rand_act());
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
